// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if
//   Handshake bundle for one flow-controlled pipeline stage.
//   master modport: upstream/downstream side that drives the stage inputs.
//   slave modport : the stage itself.
//   Signals:
//     flush      - kill all held entries and any same-cycle input
//     in_valid   - upstream offers in_data/in_ctrl
//     in_ready   - stage can accept this cycle
//     in_data    - payload (DATA_W)
//     in_ctrl    - control bits (CTRL_W)
//     out_valid  - out_data/out_ctrl hold a valid entry
//     out_ready  - downstream accepts this cycle
//     out_data   - payload of head entry
//     out_ctrl   - control bits of head entry, zero when out_valid=0
//     occupancy  - number of entries held (0..2)
interface pipe_stage_skid_if #(
  parameter int DATA_W = 142,
  parameter int CTRL_W = 6
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Flow-controlled pipeline register carrying a packed payload and a
//   separate control-bit vector between two pipeline stages.
//   Optional feature macro: PIPE_SKID_EN
//     defined   - 2-entry storage (head + skid); in_ready depends only on
//                 the state register, never on out_ready.
//     undefined - single entry; in_ready = !reset & (!out_valid | out_ready).
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high reset
//     bus   - pipe_stage_skid_if.slave (handshake, data, ctrl, flush,
//             occupancy)
module pipe_stage_skid #(
  parameter int DATA_W = 142,
  parameter int CTRL_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_skid_if.slave bus
);

  // State value doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
`endif

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;

  assign w_out_valid = (r_state != ST_EMPTY);

`ifdef PIPE_SKID_EN
  // Registered-only decode: breaks the out_ready -> in_ready path.
  assign w_in_ready = !reset && (r_state != ST_TWO);
`else
  // Single entry: may accept in the same cycle the head drains.
  assign w_in_ready = !reset && (!w_out_valid || bus.out_ready);
`endif

  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = w_out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
`ifdef PIPE_SKID_EN
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
`endif
    end else if (bus.flush) begin
      // Data registers are left alone so out_data keeps its last value.
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state     <= ST_ONE;
            r_main_data <= bus.in_data;
            r_main_ctrl <= bus.in_ctrl;
          end
        end
        ST_ONE: begin
`ifdef PIPE_SKID_EN
          if (w_in_fire && w_out_fire) begin
            r_main_data <= bus.in_data;
            r_main_ctrl <= bus.in_ctrl;
          end else if (w_in_fire) begin
            // Head is stalled: park the new entry behind it.
            r_state     <= ST_TWO;
            r_skid_data <= bus.in_data;
            r_skid_ctrl <= bus.in_ctrl;
          end else if (w_out_fire) begin
            r_state <= ST_EMPTY;
          end
`else
          // in_fire while full implies out_fire in the same cycle.
          if (w_in_fire) begin
            r_main_data <= bus.in_data;
            r_main_ctrl <= bus.in_ctrl;
          end else if (w_out_fire) begin
            r_state <= ST_EMPTY;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        ST_TWO: begin
          if (w_out_fire) begin
            r_state     <= ST_ONE;
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
          end
        end
`endif
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main_data;
  // A bubble must never present live control bits downstream.
  assign bus.out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign bus.occupancy = r_state;

endmodule
